// File: rtl/cram_wr_arb.sv
// Write-side arbiter for the colour RAM: merges Z80 byte writes, a DMA word
// stream and a fill-clear engine onto one CRAM write port (CPU > DMA > clear).
module cram_wr_arb #(
    parameter int AW = 8,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cpu_wr,
    input  logic [AW:0]   cpu_addr,
    input  logic [7:0]    cpu_data,
    input  logic          dma_req,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_data,
    output logic          dma_ack,
    input  logic          clr_start,
    input  logic [DW-1:0] clr_data,
    output logic          clr_busy,
    output logic          clr_done,
    output logic [AW-1:0] cram_addr,
    output logic [DW-1:0] cram_data,
    output logic          cram_we
);

    typedef enum logic {IDLE, FILL} clr_state_t;

    clr_state_t    clr_state;
    logic [7:0]    lo_latch;
    logic [AW-1:0] clr_cnt;
    logic [DW-1:0] fill_val;

    logic cpu_lo;
    logic cpu_hi;
    logic dma_grant;
    logic fill_slot;
    logic fill_last;

    // dma_ack high means a DMA word was granted last edge, so the requester
    // has not yet had a chance to present the next word.
    assign cpu_lo    = cpu_wr & ~cpu_addr[0];
    assign cpu_hi    = cpu_wr &  cpu_addr[0];
    assign dma_grant = dma_req & ~cpu_hi & ~dma_ack;
    assign fill_slot = (clr_state == FILL) & ~cpu_hi & ~dma_grant;
    assign fill_last = fill_slot & (clr_cnt == {AW{1'b1}});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clr_state <= IDLE;
            lo_latch  <= '0;
            clr_cnt   <= '0;
            fill_val  <= '0;
            dma_ack   <= 1'b0;
            clr_busy  <= 1'b0;
            clr_done  <= 1'b0;
            cram_addr <= '0;
            cram_data <= '0;
            cram_we   <= 1'b0;
        end else begin
            cram_we  <= cpu_hi | dma_grant | fill_slot;
            dma_ack  <= dma_grant;
            clr_done <= fill_last;

            if (cpu_lo)
                lo_latch <= cpu_data;

            // Address and data only move on a real write; otherwise they hold.
            if (cpu_hi) begin
                cram_addr <= cpu_addr[AW:1];
                cram_data <= DW'({cpu_data, lo_latch});
            end else if (dma_grant) begin
                cram_addr <= dma_addr;
                cram_data <= dma_data;
            end else if (fill_slot) begin
                cram_addr <= clr_cnt;
                cram_data <= fill_val;
            end

            case (clr_state)
                IDLE: begin
                    clr_busy <= clr_start;
                    if (clr_start) begin
                        fill_val  <= clr_data;
                        clr_cnt   <= '0;
                        clr_state <= FILL;
                    end
                end
                FILL: begin
                    // Busy stays high through the clr_done cycle and drops after.
                    clr_busy <= 1'b1;
                    if (fill_slot) begin
                        clr_cnt <= clr_cnt + 1'b1;
                        if (fill_last)
                            clr_state <= IDLE;
                    end
                end
                default: clr_state <= IDLE;
            endcase
        end
    end

endmodule
